// File: rtl/uart_program_loader.sv
// uart_program_loader: receives a framed program image over UART RX and
// writes it word-by-word into memory from address 0, holding the CPU in
// reset while the load is in progress.
module uart_program_loader #(
    parameter int unsigned CLK_HZ       = 50000000,
    parameter int unsigned BAUD         = 115200,
    parameter int unsigned ADDR_WIDTH   = 16,
    parameter int unsigned TIMEOUT_BITS = 64
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  rx,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]           mem_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  err
);

    // CLKS_PER_BIT must be at least 4 for the mid-bit sampling to work
    localparam int unsigned CPB       = CLK_HZ / BAUD;
    localparam int unsigned CW        = $clog2(CPB);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CPB - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CPB / 2 - 1);
    localparam int unsigned TMO       = TIMEOUT_BITS * CPB;
    localparam int unsigned TW        = $clog2(TMO);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TMO - 1);
    localparam logic [7:0]    SYNC      = 8'hA5;

    // ------------------------------------------------------------------
    // RX front end
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    logic            rx_s1, rx_s2, rx_d;
    rx_state_t       rx_state, rx_state_n;
    logic [CW-1:0]   rx_cnt, rx_cnt_n;
    logic [2:0]      rx_bit, rx_bit_n;
    logic [7:0]      rx_shift, rx_shift_n;
    logic            byte_valid;
    logic            frame_err;
    logic [7:0]      rx_byte;

    // two-flop synchronizer plus one delay flop for falling-edge detection
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
        end
    end

    // receiver state register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_bit   <= rx_bit_n;
            rx_shift <= rx_shift_n;
        end
    end

    // receiver next-state: half-bit start check, then full-bit spaced samples
    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt;
        rx_bit_n   = rx_bit;
        rx_shift_n = rx_shift;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (rx_d && !rx_s2) begin
                    rx_state_n = RX_START;
                    rx_cnt_n   = '0;
                end
            end
            RX_START: begin
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_n   = '0;
                    rx_bit_n   = '0;
                    rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_n = rx_cnt + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_n   = '0;
                    rx_shift_n = {rx_s2, rx_shift[7:1]};
                    rx_bit_n   = rx_bit + 3'd1;
                    if (rx_bit == 3'd7)
                        rx_state_n = RX_STOP;
                end else begin
                    rx_cnt_n = rx_cnt + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt == BIT_LAST) begin
                    byte_valid = rx_s2;
                    frame_err  = !rx_s2;
                    rx_cnt_n   = '0;
                    rx_state_n = RX_IDLE;
                end else begin
                    rx_cnt_n = rx_cnt + 1'b1;
                end
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    assign rx_byte = rx_shift;

    // ------------------------------------------------------------------
    // Frame parser
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, ERROR} state_t;

    state_t          state, state_n;
    logic [7:0]      len_hi;
    logic [15:0]     len;
    logic [15:0]     word_cnt;
    logic [7:0]      data_hi;
    logic [7:0]      chk;
    logic [TW-1:0]   tmo_cnt;
    logic            active;
    logic            is_sync;

    assign active  = (state != IDLE) && (state != ERROR);
    assign is_sync = byte_valid && (rx_byte == SYNC);

    // frame state register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            state <= IDLE;
        else
            state <= state_n;
    end

    // frame next-state; aborts override the byte-driven transitions
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (is_sync) state_n = LEN_HI;
            LEN_HI:  if (byte_valid) state_n = LEN_LO;
            LEN_LO:  if (byte_valid) state_n = ({len_hi, rx_byte} == 16'd0) ? CHECK : DATA_HI;
            DATA_HI: if (byte_valid) state_n = DATA_LO;
            DATA_LO: if (byte_valid) state_n = (word_cnt == len - 16'd1) ? CHECK : DATA_HI;
            CHECK:   if (byte_valid) state_n = (rx_byte == chk) ? IDLE : ERROR;
            ERROR:   if (is_sync) state_n = LEN_HI;
            default: state_n = IDLE;
        endcase
        if (active && (frame_err || (!byte_valid && tmo_cnt == TMO_LAST)))
            state_n = ERROR;
    end

    // frame datapath: lengths, checksum, write port, status outputs
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_hold  <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            len_hi    <= '0;
            len       <= '0;
            word_cnt  <= '0;
            data_hi   <= '0;
            chk       <= '0;
            tmo_cnt   <= '0;
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;
            if (mem_we)
                mem_addr <= mem_addr + 1'b1;
            if (!active || byte_valid)
                tmo_cnt <= '0;
            else
                tmo_cnt <= tmo_cnt + 1'b1;
            if (state_n == ERROR && state != ERROR)
                err <= 1'b1;
            case (state)
                IDLE, ERROR: begin
                    if (is_sync) begin
                        cpu_hold <= 1'b1;
                        err      <= 1'b0;
                        mem_addr <= '0;
                        chk      <= '0;
                    end
                end
                LEN_HI: begin
                    if (byte_valid) begin
                        len_hi <= rx_byte;
                        chk    <= chk ^ rx_byte;
                    end
                end
                LEN_LO: begin
                    if (byte_valid) begin
                        len      <= {len_hi, rx_byte};
                        word_cnt <= '0;
                        chk      <= chk ^ rx_byte;
                    end
                end
                DATA_HI: begin
                    if (byte_valid) begin
                        data_hi <= rx_byte;
                        chk     <= chk ^ rx_byte;
                    end
                end
                DATA_LO: begin
                    if (byte_valid) begin
                        mem_we    <= 1'b1;
                        mem_wdata <= {data_hi, rx_byte};
                        word_cnt  <= word_cnt + 16'd1;
                        chk       <= chk ^ rx_byte;
                    end
                end
                CHECK: begin
                    if (byte_valid && rx_byte == chk) begin
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_program_loader.sv
// tb_uart_program_loader: self-checking bench with a write scoreboard.
module tb_uart_program_loader;

    localparam int unsigned CPB = 10;

    logic        CLK;
    logic        RST;
    logic        rx;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        err;

    uart_program_loader #(
        .CLK_HZ      (1000000),
        .BAUD        (100000),
        .ADDR_WIDTH  (16),
        .TIMEOUT_BITS(16)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .rx       (rx),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t  exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   we_cnt = 0;
    int   done_cnt = 0;
    logic done_prev = 1'b0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // write scoreboard and done-pulse monitor
    always @(negedge CLK) begin
        if (mem_we) begin
            we_cnt++;
            check("we_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                wr_t e;
                e = exp_q.pop_front();
                check("we_addr", mem_addr, e.addr);
                check("we_data", mem_wdata, e.data);
            end
        end
        if (done) begin
            done_cnt++;
            check("done_hold_low", cpu_hold, 0);
            check("done_single", done_prev, 0);
        end
        done_prev = done;
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (CPB) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge CLK);
        end
        rx = stop;
        repeat (CPB) @(negedge CLK);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge CLK);
    endtask

    task automatic push_exp(input logic [15:0] a, input logic [15:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // A5 00 02 12 34 AB CD <c>
    task automatic send_frame2(input logic [7:0] c);
        send_byte(8'hA5, 1'b1);
        check("hold_after_sync", cpu_hold, 1);
        check("err_after_sync", err, 0);
        push_exp(16'h0000, 16'h1234);
        push_exp(16'h0001, 16'hABCD);
        send_byte(8'h00, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'hAB, 1'b1);
        send_byte(8'hCD, 1'b1);
        check("hold_before_chk", cpu_hold, 1);
        send_byte(c, 1'b1);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, w0;
        RST = 1'b0;
        rx  = 1'b1;
        repeat (3) @(negedge CLK);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_hold", cpu_hold, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        RST = 1'b1;
        repeat (5) @(negedge CLK);

        // good two-word frame
        d0 = done_cnt; w0 = we_cnt;
        send_frame2(8'h42);
        repeat (5) @(negedge CLK);
        check("t1_done", done_cnt - d0, 1);
        check("t1_we", we_cnt - w0, 2);
        check("t1_err", err, 0);
        check("t1_hold", cpu_hold, 0);

        // bad checksum, then recovery
        d0 = done_cnt; w0 = we_cnt;
        send_frame2(8'h43);
        repeat (5) @(negedge CLK);
        check("t2_done", done_cnt - d0, 0);
        check("t2_we", we_cnt - w0, 2);
        check("t2_err", err, 1);
        check("t2_hold", cpu_hold, 1);
        d0 = done_cnt;
        send_frame2(8'h42);
        repeat (5) @(negedge CLK);
        check("t2r_done", done_cnt - d0, 1);
        check("t2r_err", err, 0);
        check("t2r_hold", cpu_hold, 0);

        // leading junk then zero-length frame
        d0 = done_cnt; w0 = we_cnt;
        send_byte(8'h00, 1'b1);
        check("t3_hold_junk0", cpu_hold, 0);
        send_byte(8'hFF, 1'b1);
        check("t3_hold_junk1", cpu_hold, 0);
        send_byte(8'hA5, 1'b1);
        check("t3_hold_sync", cpu_hold, 1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        repeat (5) @(negedge CLK);
        check("t3_done", done_cnt - d0, 1);
        check("t3_we", we_cnt - w0, 0);
        check("t3_hold", cpu_hold, 0);

        // framing error while idle is ignored
        send_byte(8'h00, 1'b0);
        check("idle_ferr_err", err, 0);
        check("idle_ferr_hold", cpu_hold, 0);

        // glitch, then framing error mid-frame
        w0 = we_cnt;
        rx = 1'b0;
        repeat (3) @(negedge CLK);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge CLK);
        check("t4_glitch_hold", cpu_hold, 0);
        check("t4_glitch_err", err, 0);
        send_byte(8'hA5, 1'b1);
        check("t4_hold_sync", cpu_hold, 1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h12, 1'b1);
        check("t4_err_before", err, 0);
        send_byte(8'h34, 1'b0);
        repeat (2) @(negedge CLK);
        check("t4_err", err, 1);
        check("t4_hold", cpu_hold, 1);
        check("t4_we", we_cnt - w0, 0);

        // inter-byte timeout (160 cycles after last byte_valid)
        send_byte(8'hA5, 1'b1);
        check("t5_err_cleared", err, 0);
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h12, 1'b1);
        repeat (100) @(negedge CLK);
        check("t5_err_early", err, 0);
        repeat (50) @(negedge CLK);
        check("t5_err_timeout", err, 1);
        check("t5_hold", cpu_hold, 1);

        // asynchronous reset during DATA_HI
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h02, 1'b1);
        rx = 1'b0;
        repeat (3 * CPB) @(negedge CLK);
        check("t6_hold_pre", cpu_hold, 1);
        #2;
        RST = 1'b0;
        #1;
        check("t6_rst_hold", cpu_hold, 0);
        check("t6_rst_err", err, 0);
        check("t6_rst_addr", mem_addr, 0);
        check("t6_rst_we", mem_we, 0);
        rx = 1'b1;
        repeat (5) @(negedge CLK);
        RST = 1'b1;
        repeat (3 * CPB) @(negedge CLK);
        d0 = done_cnt; w0 = we_cnt;
        send_frame2(8'h42);
        repeat (5) @(negedge CLK);
        check("t6_done", done_cnt - d0, 1);
        check("t6_we", we_cnt - w0, 2);
        check("t6_hold", cpu_hold, 0);

        check("sb_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
